// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS controller: FSM state encoding,
// opcode/function constants, datapath select encodings and the one-hot
// instruction-class record produced by mips_instr_decode.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

  // The encoding is visible on the debug 'state' port, so it is fixed.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ALU operation
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;

  // Next-PC source
  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_RS     = 2'b11;

  // Register-file destination
  localparam logic [1:0] REG_RD   = 2'b00;
  localparam logic [1:0] REG_RT   = 2'b01;
  localparam logic [1:0] REG_RA   = 2'b10;

  // Register-file write-data source
  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;
  localparam logic [1:0] WD_PC    = 2'b10;

  // Exactly one bit is set for any instruction word; 'nop' also absorbs
  // every undefined opcode/function so the FSM never sees an empty class.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
  } instr_class_t;

  localparam int CLASS_W = $bits(instr_class_t);

endpackage

// File: rtl/mips_instr_decode.sv
// -----------------------------------------------------------------------------
// mips_instr_decode
// Combinational instruction classifier: maps the IR word onto a one-hot
// instruction-class vector (layout of mips_ctrl_pkg::instr_class_t).
//   instr        in  32       IR contents
//   instr_class  out CLASS_W  one-hot class; nop bit covers undefined encodings
// -----------------------------------------------------------------------------
module mips_instr_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0]        instr,
  output logic [CLASS_W-1:0] instr_class
);

  instr_class_t cls;

  always_comb begin
    // NOTE: every bit gets a default before the case, so no path can leave a
    // bit unassigned and infer a latch.
    cls = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: cls.nop  = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.nop = 1'b1;
    endcase
  end

  assign instr_class = cls;

  // Register and immediate fields are consumed by the datapath, not here.
  logic unused_fields;
  assign unused_fields = ^instr[25:6];

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle MIPS controller. Steps a shared-memory datapath through
// FETCH/DECODE/EXEC/MEM/WB one instruction at a time; every memory step waits
// on a mem_req/mem_ready handshake with a variable-latency unified memory.
// Supports addu, subu, ori, lw, sw, beq, lui, j, jal, jr and nop.
//
// Parameters
//   WAIT_LIMIT  stalled-request cycles before mem_err sets (0 = never)
//   CNT_W       perf counter width (perf build only)
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   instr[31:0]             IR contents
//   eq                      rs==rt from datapath, used in EXEC of beq
//   mem_ready               memory acknowledge
//   mem_req, mem_wr         memory request / write qualifier
//   ir_we, pc_we, grf_we    IR, PC, register-file write enables
//   npc_sel, reg_dst,
//   wd_sel, alu_src,
//   alu_op, ext_sign        datapath selects (encodings in mips_ctrl_pkg)
//   state[2:0]              debug view of the FSM state
//   mem_err                 sticky memory-timeout flag
// Optional build macro MULTICYCLE_CTRL_PERF_EN adds
//   cycle_cnt[CNT_W]        cycles since reset
//   instr_cnt[CNT_W]        returns to FETCH (completed instructions)
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      instr,
  input  logic             eq,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             grf_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             ext_sign,
  output logic [2:0]       state,
  output logic             mem_err
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

  state_t       cur_state;
  state_t       next_state;
  instr_class_t cls;
  logic [WAIT_W-1:0] wait_cnt;

  mips_instr_decode u_decode (
    .instr       (instr),
    .instr_class (cls)
  );

  assign state = cur_state;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) cur_state <= S_FETCH;
    else          cur_state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // Next state, handshake and write enables
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = cur_state;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    npc_sel    = NPC_PC4;
    grf_we     = 1'b0;
    reg_dst    = REG_RD;
    wd_sel     = WD_ALU;

    unique case (cur_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          npc_sel    = NPC_PC4;
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        if (cls.addu || cls.subu || cls.ori || cls.lui ||
            cls.lw || cls.sw || cls.beq) begin
          next_state = S_EXEC;
        end else if (cls.j) begin
          pc_we      = 1'b1;
          npc_sel    = NPC_JUMP;
          next_state = S_FETCH;
        end else if (cls.jr) begin
          pc_we      = 1'b1;
          npc_sel    = NPC_RS;
          next_state = S_FETCH;
        end else if (cls.jal) begin
          next_state = S_WB;
        end else begin
          next_state = S_FETCH;  // nop / undefined: no side effects
        end
      end

      S_EXEC: begin
        if (cls.beq) begin
          pc_we      = eq;
          npc_sel    = NPC_BRANCH;
          next_state = S_FETCH;
        end else if (cls.lw || cls.sw) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_wr  = cls.sw;
        if (mem_ready) next_state = cls.sw ? S_FETCH : S_WB;
      end

      S_WB: begin
        grf_we     = 1'b1;
        next_state = S_FETCH;
        if (cls.jal) begin
          reg_dst = REG_RA;
          wd_sel  = WD_PC;
          pc_we   = 1'b1;
          npc_sel = NPC_JUMP;
        end else if (cls.lw) begin
          reg_dst = REG_RT;
          wd_sel  = WD_MEM;
        end else if (cls.ori || cls.lui) begin
          reg_dst = REG_RT;
        end
      end

      default: next_state = S_FETCH;
    endcase

    // The state register is already FETCH while reset is low, but nothing may
    // request memory or write state until reset is released.
    if (!reset_n) begin
      mem_req = 1'b0;
      mem_wr  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      grf_we  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU controls: set up in EXEC and held through MEM/WB so the address and
  // result seen by the datapath stay stable.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_src  = 1'b0;
    alu_op   = ALU_ADD;
    ext_sign = 1'b0;
    if (cur_state == S_EXEC || cur_state == S_MEM || cur_state == S_WB) begin
      if (cls.subu) begin
        alu_op = ALU_SUB;
      end else if (cls.ori) begin
        alu_src = 1'b1;
        alu_op  = ALU_OR;
      end else if (cls.lui) begin
        alu_src = 1'b1;
        alu_op  = ALU_LUI;
      end else if (cls.lw || cls.sw) begin
        alu_src  = 1'b1;
        ext_sign = 1'b1;
      end else if (cls.beq) begin
        alu_op   = ALU_SUB;
        ext_sign = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory timeout: count consecutive unacknowledged request cycles. The
  // counter saturates at the limit; mem_err is set on the edge the count
  // reaches it and only reset clears it. The FSM is never aborted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (mem_req && !mem_ready) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      if (WAIT_LIMIT != 0 && wait_cnt == WAIT_MAX - 1'b1) mem_err <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (wrap naturally)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (cur_state != S_FETCH && next_state == S_FETCH)
        instr_cnt <= instr_cnt + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl (WAIT_LIMIT=4). A per-instruction
// reference model expands each instruction into its expected cycle sequence
// (fetch stalls, decode, exec, memory stalls, write-back) and every cycle's
// outputs are compared. Directed table vectors, randomized instructions,
// a timeout sequence and a reset-during-MEM sequence are applied.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int WAIT_LIMIT = 4;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        eq;
  logic        mem_ready;
  logic        mem_req, mem_wr, ir_we, pc_we, grf_we;
  logic [1:0]  npc_sel, reg_dst, wd_sel;
  logic        alu_src, ext_sign;
  logic [2:0]  alu_op;
  logic [2:0]  state;
  logic        mem_err;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .instr     (instr),
    .eq        (eq),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .npc_sel   (npc_sel),
    .grf_we    (grf_we),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .ext_sign  (ext_sign),
    .state     (state),
    .mem_err   (mem_err)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ,
                    K_J, K_JAL, K_JR, K_NOP} kind_t;

  typedef struct {
    logic [2:0] st;
    logic       req, wr, ir, pc, grf;
    logic [1:0] npc, dst, wd;
    logic       chk_src, chk_op, chk_ext;
    logic       src, ext;
    logic [2:0] op;
    logic       rdy, eqv;   // stimulus for this cycle
  } step_t;

  step_t plan[$];
  int    stall_cnt = 0;
  logic  err_model = 1'b0;

  function automatic kind_t kind_of(input logic [31:0] w);
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h21:   return K_ADDU;
          6'h23:   return K_SUBU;
          6'h08:   return K_JR;
          default: return K_NOP;
        endcase
      end
      6'h0D:   return K_ORI;
      6'h0F:   return K_LUI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  // Latency with zero-wait memory, straight from the instruction's class.
  function automatic int base_len(input kind_t k);
    case (k)
      K_J, K_JR, K_NOP: return 2;
      K_BEQ, K_JAL:     return 3;
      K_LW:             return 5;
      default:          return 4;
    endcase
  endfunction

  function automatic step_t blank(input logic [2:0] st);
    step_t s;
    s = '{default: '0};
    s.st  = st;
    s.rdy = 1'($urandom_range(0, 1));
    s.eqv = 1'($urandom_range(0, 1));
    return s;
  endfunction

  function automatic step_t with_alu(input step_t s_in, input kind_t k);
    step_t s = s_in;
    s.chk_op = 1'b1;
    case (k)
      K_ADDU: begin s.chk_src = 1; s.src = 0; s.op = 3'b000; end
      K_SUBU: begin s.chk_src = 1; s.src = 0; s.op = 3'b001; end
      K_ORI:  begin s.chk_src = 1; s.src = 1; s.op = 3'b011; s.chk_ext = 1; s.ext = 0; end
      K_LUI:  begin s.chk_src = 1; s.src = 1; s.op = 3'b100; end
      K_LW, K_SW: begin s.chk_src = 1; s.src = 1; s.op = 3'b000; s.chk_ext = 1; s.ext = 1; end
      K_BEQ:  begin s.op = 3'b001; s.chk_ext = 1; s.ext = 1; end
      default: s.chk_op = 1'b0;
    endcase
    return s;
  endfunction

  // Expand one instruction into its expected per-cycle behaviour.
  function automatic void build_plan(input kind_t k, input logic eqv, input int fw, input int mw);
    step_t s;
    plan.delete();
    for (int i = 0; i < fw; i++) begin
      s = blank(ST_FETCH); s.req = 1; s.rdy = 0; plan.push_back(s);
    end
    s = blank(ST_FETCH); s.req = 1; s.rdy = 1; s.ir = 1; s.pc = 1; s.npc = 2'b00;
    plan.push_back(s);

    s = blank(ST_DECODE);
    if (k == K_J)  begin s.pc = 1; s.npc = 2'b10; end
    if (k == K_JR) begin s.pc = 1; s.npc = 2'b11; end
    plan.push_back(s);

    if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ}) begin
      s = with_alu(blank(ST_EXEC), k);
      if (k == K_BEQ) begin s.eqv = eqv; s.pc = eqv; s.npc = 2'b01; end
      plan.push_back(s);
    end

    if (k inside {K_LW, K_SW}) begin
      for (int i = 0; i <= mw; i++) begin
        s = with_alu(blank(ST_MEM), k);
        s.req = 1; s.wr = (k == K_SW); s.rdy = (i == mw);
        plan.push_back(s);
      end
    end

    if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_JAL}) begin
      s = (k == K_JAL) ? blank(ST_WB) : with_alu(blank(ST_WB), k);
      s.grf = 1;
      case (k)
        K_ADDU, K_SUBU: begin s.dst = 2'b00; s.wd = 2'b00; end
        K_ORI, K_LUI:   begin s.dst = 2'b01; s.wd = 2'b00; end
        K_LW:           begin s.dst = 2'b01; s.wd = 2'b01; end
        default:        begin s.dst = 2'b10; s.wd = 2'b10; s.pc = 1; s.npc = 2'b10; end
      endcase
      plan.push_back(s);
    end
  endfunction

  task automatic cmp_step(input string tag, input int i, input step_t s);
    string p;
    p = $sformatf("%s[c%0d]", tag, i);
    check({p, " state"},   state,   s.st);
    check({p, " mem_req"}, mem_req, s.req);
    check({p, " mem_wr"},  mem_wr,  s.wr);
    check({p, " ir_we"},   ir_we,   s.ir);
    check({p, " pc_we"},   pc_we,   s.pc);
    check({p, " grf_we"},  grf_we,  s.grf);
    check({p, " mem_err"}, mem_err, err_model);
    if (s.pc)  check({p, " npc_sel"}, npc_sel, s.npc);
    if (s.grf) begin
      check({p, " reg_dst"}, reg_dst, s.dst);
      check({p, " wd_sel"},  wd_sel,  s.wd);
    end
    if (s.chk_src) check({p, " alu_src"},  alu_src,  s.src);
    if (s.chk_op)  check({p, " alu_op"},   alu_op,   s.op);
    if (s.chk_ext) check({p, " ext_sign"}, ext_sign, s.ext);
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_instr(input string tag, input logic [31:0] w, input logic eqv,
                           input int fw, input int mw, input int exp_len);
    kind_t k;
    bit    left;
    int    act_len;
    k = kind_of(w);
    build_plan(k, eqv, fw, mw);
    instr   = w;
    left    = 0;
    act_len = -1;
    for (int i = 0; i < plan.size(); i++) begin
      mem_ready = plan[i].rdy;
      eq        = plan[i].eqv;
      @(negedge clk);
      cmp_step(tag, i, plan[i]);
      if (plan[i].req) begin
        if (!plan[i].rdy) begin
          stall_cnt++;
          if (WAIT_LIMIT != 0 && stall_cnt == WAIT_LIMIT) err_model = 1'b1;
        end else begin
          stall_cnt = 0;
        end
      end
      @(posedge clk); #1;
      if (state != ST_FETCH) left = 1;
      else if (left && act_len < 0) act_len = i + 1;
    end
    check({tag, " cycles"}, act_len, exp_len);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [31:0] w;
    logic        eqv;
    int          fw;
    int          mw;
    int          exp_len;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"addu",     32'h0022_1821, 1'b0, 0, 0, 4};
    vecs[1]  = '{"subu",     32'h0022_1823, 1'b0, 0, 0, 4};
    vecs[2]  = '{"ori",      32'h3422_0005, 1'b0, 0, 0, 4};
    vecs[3]  = '{"lui",      32'h3C01_1234, 1'b0, 0, 0, 4};
    vecs[4]  = '{"lw_wait3", 32'h8C22_0004, 1'b0, 0, 3, 8};
    vecs[5]  = '{"sw_fw1",   32'hAC22_0004, 1'b0, 1, 0, 5};
    vecs[6]  = '{"beq_eq1",  32'h1022_0003, 1'b1, 0, 0, 3};
    vecs[7]  = '{"beq_eq0",  32'h1022_0003, 1'b0, 0, 0, 3};
    vecs[8]  = '{"j",        32'h0800_0010, 1'b0, 0, 0, 2};
    vecs[9]  = '{"jal",      32'h0C00_0C00, 1'b0, 0, 0, 3};
    vecs[10] = '{"jr",       32'h03E0_0008, 1'b0, 0, 0, 2};
    vecs[11] = '{"nop",      32'h0000_0000, 1'b0, 0, 0, 2};
    vecs[12] = '{"bad_op",   32'hFC00_0000, 1'b0, 0, 0, 2};
    vecs[13] = '{"bad_fn",   32'h0022_183F, 1'b0, 0, 0, 2};
    vecs[14] = '{"lw_fw2",   32'h8C22_0008, 1'b0, 2, 1, 8};

    // ---- reset state ----
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    eq        = 1'b0;
    instr     = 32'h0;
    #12;
    check("reset state",   state,   ST_FETCH);
    check("reset mem_req", mem_req, 1'b0);
    check("reset ir_we",   ir_we,   1'b0);
    check("reset pc_we",   pc_we,   1'b0);
    check("reset grf_we",  grf_we,  1'b0);
    check("reset mem_wr",  mem_wr,  1'b0);
    check("reset mem_err", mem_err, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("release mem_req", mem_req, 1'b1);

    // ---- directed table ----
    foreach (vecs[i])
      run_instr(vecs[i].name, vecs[i].w, vecs[i].eqv, vecs[i].fw, vecs[i].mw, vecs[i].exp_len);

    // ---- randomized instructions (stalls kept below the timeout) ----
    for (int n = 0; n < 40; n++) begin
      logic [31:0] w;
      logic [5:0]  ops [8];
      int          sel, fw, mw;
      kind_t       k;
      ops[0] = 6'h0D; ops[1] = 6'h0F; ops[2] = 6'h23; ops[3] = 6'h2B;
      ops[4] = 6'h04; ops[5] = 6'h02; ops[6] = 6'h03; ops[7] = 6'h3F;
      w   = $urandom;
      sel = $urandom_range(0, 10);
      if (sel < 8) begin
        w[31:26] = ops[sel];
      end else begin
        w[31:26] = 6'h00;
        w[5:0]   = (sel == 8) ? 6'h21 : (sel == 9) ? 6'h23 : 6'h08;
      end
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      k  = kind_of(w);
      run_instr($sformatf("rnd%0d", n), w, 1'($urandom_range(0, 1)), fw, mw,
                base_len(k) + fw + ((k == K_LW || k == K_SW) ? mw : 0));
    end

    // ---- timeout: 6 fetch stalls exceed WAIT_LIMIT=4; FSM still proceeds ----
    check("pre-timeout mem_err", mem_err, 1'b0);
    run_instr("timeout_addu", 32'h0022_1821, 1'b0, 6, 0, 10);
    run_instr("after_timeout_lw", 32'h8C22_0004, 1'b0, 0, 2, 7);
    check("timeout sticky", mem_err, 1'b1);

    // ---- reset pulsed mid-MEM of a sw ----
    instr     = 32'hAC22_0004;
    mem_ready = 1'b1;
    @(posedge clk); #1;          // DECODE
    mem_ready = 1'b0;
    @(posedge clk); #1;          // EXEC
    @(posedge clk); #1;          // MEM, stalled
    check("sw mem state", state,  ST_MEM);
    check("sw mem_wr",    mem_wr, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst mid-mem state",   state,   ST_FETCH);
    check("rst mid-mem mem_req", mem_req, 1'b0);
    check("rst mid-mem mem_wr",  mem_wr,  1'b0);
    check("rst mid-mem mem_err", mem_err, 1'b0);
    mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("rst hold%0d mem_req", c), mem_req, 1'b0);
      check($sformatf("rst hold%0d mem_wr", c),  mem_wr,  1'b0);
      check($sformatf("rst hold%0d ir_we", c),   ir_we,   1'b0);
      check($sformatf("rst hold%0d pc_we", c),   pc_we,   1'b0);
    end
    @(posedge clk); #3;
    mem_ready = 1'b0;
    reset_n   = 1'b1;
    #1;
    check("post-rst mem_req", mem_req, 1'b1);
    check("post-rst mem_wr",  mem_wr,  1'b0);
    check("post-rst state",   state,   ST_FETCH);
    err_model = 1'b0;
    @(posedge clk); #1;
    stall_cnt = 1;               // one unacknowledged fetch cycle since release
    run_instr("post_rst_addu", 32'h0022_1821, 1'b0, 0, 0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
